// File: rtl/control_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// Also carries the core-wide data and register-index widths.
package control_pkg;

  localparam int XLEN = 32;
  localparam int MSB_REG_FILE = 5;

  localparam int WB_STARVE_LIMIT_DEF = 4;
  localparam int WB_NREQ_DEF = 2;

  typedef struct packed {
    logic [MSB_REG_FILE-1:0] rd;
    logic [XLEN-1:0]         data;
  } wb_req_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational rotate-priority picker: first valid at or after ptr.
// Ports: valid/ptr in; one-hot grant, its index and any-valid out.
module wb_rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [PW-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = ptr;
    for (int k = 0; k < N; k++) begin
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
      j = (int'(j) == N - 1) ? '0 : j + 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the RF write port: pipeline first, secondaries round-robin.
// Ports: pipe_wb_*, req_* (valid/ready) in; stall_pipe, rf_wr_* out.
module wb_port_arbiter
  import control_pkg::*;
#(
  parameter int NREQ         = WB_NREQ_DEF,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT_DEF
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               pipe_wb_valid,
  input  logic [MSB_REG_FILE-1:0]            pipe_wb_rd,
  input  logic [XLEN-1:0]                    pipe_wb_data,
  input  logic [NREQ-1:0]                    req_valid,
  input  logic [NREQ-1:0][MSB_REG_FILE-1:0]  req_rd,
  input  logic [NREQ-1:0][XLEN-1:0]          req_data,
  output logic [NREQ-1:0]                    req_ready,
  output logic                               stall_pipe,
  output logic                               rf_wr_en,
  output logic [MSB_REG_FILE-1:0]            rf_wr_addr,
  output logic [XLEN-1:0]                    rf_wr_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 4;
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   rr_idx;
  logic [PW-1:0]   st_idx;
  logic [PW-1:0]   sec_idx;
  logic [PW-1:0]   ptr_next;
  logic [NREQ-1:0] rr_gnt;
  logic [NREQ-1:0] st_gnt;
  logic [NREQ-1:0] starved;
  logic [NREQ-1:0] gnt;
  logic            rr_any;
  logic            st_any;
  logic            pipe_gnt;
  logic            sec_gnt;
  logic            stall_d;
  logic [CW-1:0]   cnt_q [NREQ];
  logic [CW-1:0]   cnt_d [NREQ];
  wb_req_t         sel;

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      starved[i] = req_valid[i] && (cnt_q[i] == LIM);
  end

  wb_rr_pick #(.N(NREQ), .PW(PW)) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (rr_gnt),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  // Starved requesters are served lowest index first.
  wb_rr_pick #(.N(NREQ), .PW(PW)) u_st (
    .valid (starved),
    .ptr   ('0),
    .grant (st_gnt),
    .idx   (st_idx),
    .any   (st_any)
  );

  // During a stall the pipeline re-presents its writeback later,
  // so its valid is ignored and the port goes to a secondary.
  always_comb begin
    gnt      = '0;
    pipe_gnt = 1'b0;
    sec_gnt  = 1'b0;
    sec_idx  = '0;
    if (rstn) begin
      if (stall_pipe && st_any) begin
        gnt     = st_gnt;
        sec_gnt = 1'b1;
        sec_idx = st_idx;
      end else if (stall_pipe || !pipe_wb_valid) begin
        gnt     = rr_gnt;
        sec_gnt = rr_any;
        sec_idx = rr_idx;
      end else begin
        pipe_gnt = 1'b1;
      end
    end
  end

  assign req_ready = gnt;

  always_comb begin
    if (pipe_gnt) begin
      sel.rd   = pipe_wb_rd;
      sel.data = pipe_wb_data;
    end else begin
      sel.rd   = req_rd[sec_idx];
      sel.data = req_data[sec_idx];
    end
  end

  assign ptr_next = (int'(sec_idx) == NREQ - 1) ? '0 : sec_idx + 1'b1;

  // Counter value includes the current cycle's wait, so a stall
  // lands in the cycle right after the limit is reached.
  always_comb begin
    stall_d = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = '0;
      if (req_valid[i] && !gnt[i])
        cnt_d[i] = (cnt_q[i] == LIM) ? LIM : cnt_q[i] + 1'b1;
      if (cnt_d[i] == LIM)
        stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr     <= '0;
      stall_pipe <= 1'b0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      for (int i = 0; i < NREQ; i++)
        cnt_q[i] <= '0;
    end else begin
      stall_pipe <= stall_d;
      for (int i = 0; i < NREQ; i++)
        cnt_q[i] <= cnt_d[i];
      if (sec_gnt)
        rr_ptr <= ptr_next;
      // x0 grants complete the handshake but never write.
      rf_wr_en <= (pipe_gnt || sec_gnt) && (sel.rd != '0);
      if (pipe_gnt || sec_gnt) begin
        rf_wr_addr <= sel.rd;
        rf_wr_data <= sel.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter with a behavioural model.
// Directed scenarios followed by a randomized held-request run.
module tb_wb_port_arbiter;
  import control_pkg::*;

  localparam int N   = 2;
  localparam int LIM = 4;

  logic                          clk = 1'b0;
  logic                          rstn = 1'b1;
  logic                          pipe_wb_valid;
  logic [MSB_REG_FILE-1:0]       pipe_wb_rd;
  logic [XLEN-1:0]               pipe_wb_data;
  logic [N-1:0]                  req_valid;
  logic [N-1:0][MSB_REG_FILE-1:0] req_rd;
  logic [N-1:0][XLEN-1:0]        req_data;
  logic [N-1:0]                  req_ready;
  logic                          stall_pipe;
  logic                          rf_wr_en;
  logic [MSB_REG_FILE-1:0]       rf_wr_addr;
  logic [XLEN-1:0]               rf_wr_data;

  int errors = 0;
  int checks = 0;

  int                      m_wait [N];
  int                      m_ptr;
  bit                      m_stall;
  int                      m_win;
  logic [N-1:0]            exp_ready;
  logic                    exp_en;
  logic [MSB_REG_FILE-1:0] exp_addr;
  logic [XLEN-1:0]         exp_data;

  always #5 clk = ~clk;

  wb_port_arbiter #(.NREQ(N), .STARVE_LIMIT(LIM)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .pipe_wb_valid (pipe_wb_valid),
    .pipe_wb_rd    (pipe_wb_rd),
    .pipe_wb_data  (pipe_wb_data),
    .req_valid     (req_valid),
    .req_rd        (req_rd),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .stall_pipe    (stall_pipe),
    .rf_wr_en      (rf_wr_en),
    .rf_wr_addr    (rf_wr_addr),
    .rf_wr_data    (rf_wr_data)
  );

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_wait[i] = 0;
    m_ptr    = 0;
    m_stall  = 0;
    m_win    = -1;
    exp_en   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
  endtask

  // Winner: -2 pipeline, -1 nobody, else requester index.
  task automatic model_eval();
    m_win = -1;
    if (m_stall)
      for (int i = 0; i < N; i++)
        if (m_win < 0 && req_valid[i] && m_wait[i] == LIM) m_win = i;
    if (m_win < 0) begin
      if (!m_stall && pipe_wb_valid) m_win = -2;
      else
        for (int k = 0; k < N; k++)
          if (m_win == -1 && req_valid[(m_ptr + k) % N])
            m_win = (m_ptr + k) % N;
    end
    exp_ready = (m_win >= 0) ? (N'(1) << m_win) : '0;
  endtask

  task automatic model_commit();
    if (m_win == -2) begin
      exp_en   = (pipe_wb_rd != 0);
      exp_addr = pipe_wb_rd;
      exp_data = pipe_wb_data;
    end else if (m_win >= 0) begin
      exp_en   = (req_rd[m_win] != 0);
      exp_addr = req_rd[m_win];
      exp_data = req_data[m_win];
      m_ptr    = (m_win + 1) % N;
    end else begin
      exp_en = 1'b0;
    end
    m_stall = 0;
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] || m_win == i) m_wait[i] = 0;
      else if (m_wait[i] < LIM) m_wait[i]++;
      if (m_wait[i] == LIM) m_stall = 1;
    end
  endtask

  task automatic idle_inputs();
    pipe_wb_valid = 1'b0;
    pipe_wb_rd    = '0;
    pipe_wb_data  = '0;
    req_valid     = '0;
  endtask

  task automatic test_reset();
    rstn          = 1'b0;
    pipe_wb_valid = 1'b1;
    pipe_wb_rd    = 5'd9;
    pipe_wb_data  = 32'h55;
    req_valid     = 2'b11;
    req_rd        = '{5'd1, 5'd2};
    req_data      = '{32'h1, 32'h2};
    model_reset();
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if ({req_ready, stall_pipe, rf_wr_en, rf_wr_addr, rf_wr_data} !== '0) begin
        errors++;
        $display("FAIL reset_hold got rdy=%b st=%b en=%b a=%0d d=%h exp all 0",
                 req_ready, stall_pipe, rf_wr_en, rf_wr_addr, rf_wr_data);
      end
    end
    @(negedge clk);
    idle_inputs();
    rstn = 1'b1;
    #1 model_eval();
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_rel_ready got=%b exp=00", req_ready);
    end
    @(posedge clk);
    model_commit();
    #1;
    checks++;
    if (rf_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_rel_en got=%b exp=0", rf_wr_en);
    end
  endtask

  task automatic test_pipe_write();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle_inputs();
      if (c == 0) begin
        pipe_wb_valid = 1'b1;
        pipe_wb_rd    = 5'd5;
        pipe_wb_data  = 32'hDEADBEEF;
      end
      #1 model_eval();
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL pipe_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready);
      end
      @(posedge clk);
      model_commit();
      #1;
      checks++;
      if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {exp_en, exp_addr, exp_data}) begin
        errors++;
        $display("FAIL pipe_rf c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c,
                 rf_wr_en, rf_wr_addr, rf_wr_data, exp_en, exp_addr, exp_data);
      end
      if (c == 0) begin
        checks++;
        if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
          errors++;
          $display("FAIL pipe_rf_const got=%b/%0d/%h exp=1/5/deadbeef",
                   rf_wr_en, rf_wr_addr, rf_wr_data);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      idle_inputs();
      if (c < 4) begin
        req_valid   = 2'b11;
        req_rd[0]   = 5'd3;
        req_rd[1]   = 5'd7;
        req_data[0] = $urandom;
        req_data[1] = $urandom;
      end
      #1 model_eval();
      want = (c == 4) ? 2'b00 : ((c % 2) ? 2'b10 : 2'b01);
      checks++;
      if (req_ready !== want || req_ready !== exp_ready) begin
        errors++;
        $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, want);
      end
      @(posedge clk);
      model_commit();
      #1;
      checks++;
      if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {exp_en, exp_addr, exp_data}) begin
        errors++;
        $display("FAIL rr_rf c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c,
                 rf_wr_en, rf_wr_addr, rf_wr_data, exp_en, exp_addr, exp_data);
      end
    end
  endtask

  task automatic run_starve(input int last, input bit do_reset);
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      pipe_wb_valid = 1'b1;
      pipe_wb_rd    = 5'($urandom_range(1, 31));
      pipe_wb_data  = $urandom;
      req_valid     = (c <= 4) ? 2'b01 : 2'b00;
      if (c == 0) begin
        req_rd[0]   = 5'd12;
        req_data[0] = 32'hCAFE0000;
      end
      #1 model_eval();
      checks++;
      if (stall_pipe !== (c == 4) || stall_pipe !== m_stall) begin
        errors++;
        $display("FAIL starve_stall c=%0d got=%b exp=%b", c, stall_pipe, c == 4);
      end
      checks++;
      if (req_ready !== ((c == 4) ? 2'b01 : 2'b00) || req_ready !== exp_ready) begin
        errors++;
        $display("FAIL starve_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready);
      end
      if (do_reset && c == 4) begin
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({stall_pipe, req_ready, rf_wr_en} !== 4'b0) begin
          errors++;
          $display("FAIL async_rst got st=%b rdy=%b en=%b exp=0/00/0",
                   stall_pipe, req_ready, rf_wr_en);
        end
        model_reset();
        return;
      end
      @(posedge clk);
      model_commit();
      #1;
      checks++;
      if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {exp_en, exp_addr, exp_data}) begin
        errors++;
        $display("FAIL starve_rf c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c,
                 rf_wr_en, rf_wr_addr, rf_wr_data, exp_en, exp_addr, exp_data);
      end
      if (c == 4) begin
        checks++;
        if ({rf_wr_addr, rf_wr_data} !== {5'd12, 32'hCAFE0000}) begin
          errors++;
          $display("FAIL starve_win got=%0d/%h exp=12/cafe0000", rf_wr_addr, rf_wr_data);
        end
      end
    end
  endtask

  task automatic test_starvation();
    run_starve(5, 1'b0);
  endtask

  task automatic test_x0();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle_inputs();
      if (c == 0) begin
        req_valid   = 2'b10;
        req_rd[1]   = 5'd0;
        req_data[1] = 32'h1234;
      end
      #1 model_eval();
      checks++;
      if (req_ready !== exp_ready || stall_pipe !== 1'b0) begin
        errors++;
        $display("FAIL x0_ready c=%0d got=%b/%b exp=%b/0", c, req_ready, stall_pipe, exp_ready);
      end
      @(posedge clk);
      model_commit();
      #1;
      checks++;
      if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b0, 5'd0, 32'h1234}) begin
        errors++;
        $display("FAIL x0_rf c=%0d got=%b/%0d/%h exp=0/0/1234", c,
                 rf_wr_en, rf_wr_addr, rf_wr_data);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    run_starve(4, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rstn          = 1'b1;
    pipe_wb_valid = 1'b0;
    req_valid     = 2'b01;
    #1 model_eval();
    checks++;
    if (req_ready !== 2'b01 || req_ready !== exp_ready) begin
      errors++;
      $display("FAIL post_rst_ready got=%b exp=01", req_ready);
    end
    @(posedge clk);
    model_commit();
    #1;
    checks++;
    if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {1'b1, 5'd12, 32'hCAFE0000}) begin
      errors++;
      $display("FAIL post_rst_rf got=%b/%0d/%h exp=1/12/cafe0000",
               rf_wr_en, rf_wr_addr, rf_wr_data);
    end
  endtask

  task automatic test_random();
    m_win = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      pipe_wb_valid = ($urandom_range(0, 3) != 0);
      pipe_wb_rd    = 5'($urandom);
      pipe_wb_data  = $urandom;
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || m_win == i) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_rd[i]    = 5'($urandom);
          req_data[i]  = $urandom;
        end
      #1 model_eval();
      checks++;
      if (req_ready !== exp_ready || stall_pipe !== m_stall) begin
        errors++;
        $display("FAIL rand_arb c=%0d got=%b/%b exp=%b/%b", c,
                 req_ready, stall_pipe, exp_ready, m_stall);
      end
      @(posedge clk);
      model_commit();
      #1;
      checks++;
      if ({rf_wr_en, rf_wr_addr, rf_wr_data} !== {exp_en, exp_addr, exp_data}) begin
        errors++;
        $display("FAIL rand_rf c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c,
                 rf_wr_en, rf_wr_addr, rf_wr_data, exp_en, exp_addr, exp_data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_pipe_write();
    test_round_robin();
    test_starvation();
    test_x0();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
